// File: rtl/subband_synth_combiner.sv
// subband_synth_combiner: weights one 16-band frame by programmable gains and sums it serially into one rounded, saturated sample
//   clk_en        gated sample clock
//   reset         synchronous, active-high; aborts any frame and reloads unity gains
//   band_in       flattened subband frame, band k at [k*BW +: BW] (sfix27_En22)
//   band_valid    frame strobe; accepted in IDLE or DONE, dropped (overrun) in ACCUM
//   gain_wr_*     gain register write port (sfix12_En10); gain_wr_rdy low while accumulating
//   busy          frame in progress
//   sample_out    reconstructed sample (sfix10_En9), held between pulses
//   out_valid     one-cycle pulse 17 edges after the accepting edge
//   overrun       sticky dropped-frame flag
module subband_synth_combiner #(
    parameter int NB    = 16,
    parameter int BW    = 27,
    parameter int GW    = 12,
    parameter int OUT_W = 10,
    parameter int SHIFT = 23,
    parameter int ACC_W = BW + GW + 4
) (
    input  logic                    clk_en,
    input  logic                    reset,
    input  logic [NB*BW-1:0]        band_in,
    input  logic                    band_valid,
    input  logic                    gain_wr_en,
    input  logic [$clog2(NB)-1:0]   gain_wr_addr,
    input  logic [GW-1:0]           gain_wr_data,
    output logic                    gain_wr_rdy,
    output logic                    busy,
    output logic [OUT_W-1:0]        sample_out,
    output logic                    out_valid,
    output logic                    overrun
);
    localparam int AW = $clog2(NB);
    localparam int PW = BW + GW;
    localparam logic [AW-1:0]          LAST  = AW'(NB - 1);
    localparam logic signed [GW-1:0]   UNITY = GW'(2 ** (GW - 2));
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state;

    logic signed [BW-1:0]    snap [NB];
    logic signed [GW-1:0]    gain [NB];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rnd;
    logic signed [PW-1:0]    prod;
    logic [OUT_W-1:0]        sat;
    logic [AW-1:0]           idx;
    logic                    accept;

    assign gain_wr_rdy = state != ACCUM;
    assign busy        = state != IDLE;
    assign accept      = band_valid && state != ACCUM;
    assign prod        = PW'(snap[idx]) * PW'(gain[idx]);
    // Round half up by biasing before the arithmetic shift.
    assign rnd         = (acc + HALF) >>> SHIFT;
    assign sat         = rnd > MAXV ? MAXV[OUT_W-1:0] : rnd < MINV ? MINV[OUT_W-1:0] : rnd[OUT_W-1:0];

    // Snapshot needs no reset: it is only read after an accept has loaded it.
    always_ff @(posedge clk_en) begin
        if (accept)
            for (int k = 0; k < NB; k++)
                snap[k] <= band_in[k*BW +: BW];
    end

    always_ff @(posedge clk_en) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            idx        <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < NB; k++)
                gain[k] <= UNITY;
        end else begin
            out_valid <= state == DONE;
            if (state == DONE)
                sample_out <= sat;
            // Writes are blocked during ACCUM so a frame sees one consistent gain set;
            // a write on the accepting edge lands before the first product.
            if (gain_wr_en && gain_wr_rdy)
                gain[gain_wr_addr] <= gain_wr_data;
            if (band_valid && state == ACCUM)
                overrun <= 1'b1;
            if (accept) begin
                state <= ACCUM;
                acc   <= '0;
                idx   <= '0;
            end else if (state == ACCUM) begin
                acc <= acc + ACC_W'(prod);
                idx <= idx + 1'b1;
                if (idx == LAST)
                    state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_subband_synth_combiner.sv
// tb_subband_synth_combiner: checks the combiner against a frame-level arithmetic model
module tb_subband_synth_combiner;
    localparam int NB = 16, BW = 27, GW = 12, OUT_W = 10;

    logic              clk_en = 1'b0;
    logic              reset = 1'b1;
    logic [NB*BW-1:0]  band_in;
    logic              band_valid = 1'b0;
    logic              gain_wr_en = 1'b0;
    logic [3:0]        gain_wr_addr = '0;
    logic [GW-1:0]     gain_wr_data = '0;
    logic              gain_wr_rdy, busy, out_valid, overrun;
    logic [OUT_W-1:0]  sample_out;

    logic signed [BW-1:0] bands [NB];

    int     total = 0, bad = 0;
    int     cyc = 0, start = -1000, due = -1;
    longint mgain [NB];
    longint pend = 0, exp_s = 0;
    bit     ovr = 0;

    subband_synth_combiner dut (
        .clk_en(clk_en), .reset(reset), .band_in(band_in), .band_valid(band_valid),
        .gain_wr_en(gain_wr_en), .gain_wr_addr(gain_wr_addr), .gain_wr_data(gain_wr_data),
        .gain_wr_rdy(gain_wr_rdy), .busy(busy), .sample_out(sample_out),
        .out_valid(out_valid), .overrun(overrun)
    );

    always #5 clk_en = ~clk_en;

    always_comb begin
        band_in = '0;
        for (int k = 0; k < NB; k++)
            band_in[k*BW +: BW] = bands[k];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Weighted sum in plain integers, then round half up at 2^-9 and clamp.
    function automatic longint model_out();
        longint s = 0;
        for (int k = 0; k < NB; k++)
            s += longint'(bands[k]) * mgain[k];
        s = (s + 64'sd4194304) >>> 23;
        return s > 511 ? 511 : s < -512 ? -512 : s;
    endfunction

    task automatic step();
        int rel = cyc - start;
        bit acc_win = rel >= 1 && rel <= 16;
        bit pv = 0;
        if (!reset) begin
            chk("rdy", gain_wr_rdy, !acc_win);
            chk("busy", busy, acc_win || rel == 17);
        end
        @(posedge clk_en);
        if (reset) begin
            start = -1000; due = -1; exp_s = 0; ovr = 0;
            for (int k = 0; k < NB; k++) mgain[k] = 1024;
        end else begin
            pv = cyc == due;
            if (pv) exp_s = pend;
            if (gain_wr_en && !acc_win) mgain[gain_wr_addr] = longint'($signed(gain_wr_data));
            if (band_valid && acc_win) ovr = 1;
            if (band_valid && !acc_win) begin
                start = cyc; due = cyc + 17; pend = model_out();
            end
        end
        #1;
        chk("out_valid", out_valid, pv);
        chk("sample", longint'($signed(sample_out)), exp_s);
        chk("overrun", overrun, ovr);
        cyc++;
    endtask

    task automatic set_one(input int k, input longint v);
        for (int j = 0; j < NB; j++) bands[j] = '0;
        bands[k] = BW'(v);
    endtask

    task automatic frame(input string tag, input longint expv);
        band_valid = 1'b1;
        step();
        band_valid = 1'b0;
        for (int k = 0; k < NB; k++) bands[k] = BW'($urandom);
        repeat (17) step();
        chk(tag, longint'($signed(sample_out)), expv);
    endtask

    initial begin
        for (int k = 0; k < NB; k++) bands[k] = '0;
        for (int k = 0; k < NB; k++) mgain[k] = 1024;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_sample", longint'($signed(sample_out)), 0);

        set_one(0, 64'sd2097152);
        frame("unity_b0", 256);
        chk("idle_after", busy, 0);
        for (int k = 0; k < NB; k++) bands[k] = BW'(-(2 ** 26));
        frame("sat_low", -512);
        for (int k = 0; k < NB; k++) bands[k] = BW'(2 ** 26 - 1);
        frame("sat_high", 511);
        set_one(0, 4096);
        frame("round_up", 1);
        set_one(0, -4096);
        frame("round_neg", 0);
        set_one(0, 4095);
        frame("round_below", 0);

        gain_wr_en = 1'b1; gain_wr_addr = 4'd3; gain_wr_data = 12'hE00;
        step();
        gain_wr_en = 1'b0;
        set_one(3, 64'sd2097152);
        band_valid = 1'b1;
        step();
        band_valid = 1'b0;
        gain_wr_en = 1'b1; gain_wr_data = 12'h400;
        repeat (3) step();
        chk("rdy_accum", gain_wr_rdy, 0);
        gain_wr_en = 1'b0;
        repeat (14) step();
        chk("gain_half", longint'($signed(sample_out)), -128);
        set_one(3, 64'sd2097152);
        frame("gain_kept", -128);

        set_one(0, 64'sd2097152);
        gain_wr_en = 1'b1; gain_wr_data = 12'h400;
        band_valid = 1'b1;
        step();
        gain_wr_en = 1'b0; band_valid = 1'b0;
        repeat (4) step();
        band_valid = 1'b1;
        step();
        band_valid = 1'b0;
        chk("ovr_set", overrun, 1);
        repeat (11) step();
        band_valid = 1'b1;
        step();
        band_valid = 1'b0;
        chk("b2b_first", longint'($signed(sample_out)), 256);
        repeat (17) step();
        chk("b2b_second", longint'($signed(sample_out)), 256);
        chk("ovr_sticky", overrun, 1);

        gain_wr_en = 1'b1; gain_wr_addr = 4'd3; gain_wr_data = 12'hE00;
        step();
        gain_wr_en = 1'b0;
        set_one(3, 64'sd2097152);
        band_valid = 1'b1;
        step();
        band_valid = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovr", overrun, 0);
        repeat (12) step();
        set_one(3, 64'sd2097152);
        frame("unity_reload", 256);

        repeat (600) begin
            band_valid   = ($urandom % 8) == 0;
            gain_wr_en   = ($urandom % 4) == 0;
            gain_wr_addr = 4'($urandom);
            gain_wr_data = GW'($urandom);
            reset        = ($urandom % 250) == 0;
            for (int k = 0; k < NB; k++)
                bands[k] = ($urandom % 2) ? BW'($urandom) : BW'($signed(20'($urandom)));
            step();
        end
        band_valid = 1'b0; gain_wr_en = 1'b0; reset = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
